// File: rtl/central_register_bank_pkg.sv
// Shared widths, register indices and the G write-path combiner for the central register bank.
package central_register_bank_pkg;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned EDOP_SHIFT = 7;
    localparam int unsigned S2_BIT     = 15;
    localparam int unsigned S1_BIT     = 14;

    localparam int unsigned NREG  = 5;
    localparam int unsigned REG_A = 0;
    localparam int unsigned REG_L = 1;
    localparam int unsigned REG_Q = 2;
    localparam int unsigned REG_Z = 3;
    localparam int unsigned REG_G = 4;

    // Active-high decode of the five G write gates.
    typedef struct packed {
        logic wg1;
        logic wg3;
        logic wg4;
        logic wg5;
        logic wedop;
    } g_wgates_t;

    // All active G write paths are wired-ORed together.
    function automatic logic [WIDTH-1:0] g_write_mux(input logic [WIDTH-1:0] wl,
                                                     input g_wgates_t        g);
        logic [WIDTH-1:0] v;
        v = '0;
        if (g.wg1)   v = v | wl;
        if (g.wg3)   v = v | {wl[WIDTH-2:0], wl[WIDTH-1]};
        if (g.wg4)   v = v | {wl[WIDTH-1], wl[WIDTH-1:1]};
        if (g.wg5)   v = v | {wl[0], wl[WIDTH-1:1]};
        if (g.wedop) v = v | (wl >> EDOP_SHIFT);
        return v;
    endfunction

endpackage

// File: rtl/central_register_bank_if.sv
// Service-gate bus: write data, clear/write/read gates, and the returned read bus and A flags.
interface central_register_bank_if import central_register_bank_pkg::*; ();

    logic [WIDTH-1:0] WL;
    logic             CAG, CLG1G, CQG, CZG, CGG;
    logic             WAG_n, WLG_n, WQG_n, WZG_n;
    logic             WG1G_n, WG3G_n, WG4G_n, WG5G_n, WEDOPG_n;
    logic             RAG_n, RLG_n, RQG_n, RZG_n, RGG_n;
    logic [WIDTH-1:0] RL_n;
    logic             A_OVF;
    logic             A_SGN;

    modport master (
        output WL,
        output CAG, CLG1G, CQG, CZG, CGG,
        output WAG_n, WLG_n, WQG_n, WZG_n,
        output WG1G_n, WG3G_n, WG4G_n, WG5G_n, WEDOPG_n,
        output RAG_n, RLG_n, RQG_n, RZG_n, RGG_n,
        input  RL_n, A_OVF, A_SGN
    );

    modport slave (
        input  WL,
        input  CAG, CLG1G, CQG, CZG, CGG,
        input  WAG_n, WLG_n, WQG_n, WZG_n,
        input  WG1G_n, WG3G_n, WG4G_n, WG5G_n, WEDOPG_n,
        input  RAG_n, RLG_n, RQG_n, RZG_n, RGG_n,
        output RL_n, A_OVF, A_SGN
    );

endinterface

// File: rtl/central_register_bank_gated_register.sv
// One wired-OR register: clear, then OR in write data; contents gated onto the read bus.
module central_register_bank_gated_register import central_register_bank_pkg::*; #(
    parameter int unsigned W = WIDTH
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_we,
    input  logic [W-1:0] i_wdata,
    input  logic         i_re,
    output logic [W-1:0] o_next,
    output logic [W-1:0] o_rd
);

    logic [W-1:0] r_q;
    logic [W-1:0] w_next;

    always_comb begin
        w_next = i_clr ? '0 : r_q;
        if (i_we) w_next = w_next | i_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_q <= '0;
        else          r_q <= w_next;
    end

    assign o_next = w_next;
    assign o_rd   = r_q & {W{i_re}};

endmodule

// File: rtl/central_register_bank.sv
// Central registers A, L, Q, Z, G behind the service gates, with active-low wired-OR read bus.
module central_register_bank import central_register_bank_pkg::*; (
    input  logic                    SIM_CLK,
    input  logic                    SIM_RST,
    central_register_bank_if.slave  bus
);

    logic [NREG-1:0]  w_clr;
    logic [NREG-1:0]  w_we;
    logic [NREG-1:0]  w_re;
    g_wgates_t        w_g_gates;
    logic [WIDTH-1:0] w_wdata [NREG];
    logic [WIDTH-1:0] w_next  [NREG];
    logic [WIDTH-1:0] w_rd    [NREG];
    logic [WIDTH-1:0] w_rd_or;
    logic             w_unused_next;
    logic             r_a_ovf;
    logic             r_a_sgn;

    assign w_clr     = {bus.CGG, bus.CZG, bus.CQG, bus.CLG1G, bus.CAG};
    assign w_g_gates = {~bus.WG1G_n, ~bus.WG3G_n, ~bus.WG4G_n, ~bus.WG5G_n, ~bus.WEDOPG_n};
    assign w_we      = {|w_g_gates, ~bus.WZG_n, ~bus.WQG_n, ~bus.WLG_n, ~bus.WAG_n};
    assign w_re      = ~{bus.RGG_n, bus.RZG_n, bus.RQG_n, bus.RLG_n, bus.RAG_n};

    assign w_wdata[REG_A] = bus.WL;
    assign w_wdata[REG_L] = bus.WL;
    assign w_wdata[REG_Q] = bus.WL;
    assign w_wdata[REG_Z] = bus.WL;
    assign w_wdata[REG_G] = g_write_mux(bus.WL, w_g_gates);

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        central_register_bank_gated_register #(.W(WIDTH)) u_reg (
            .i_clk   (SIM_CLK),
            .i_rst_n (SIM_RST),
            .i_clr   (w_clr[i]),
            .i_we    (w_we[i]),
            .i_wdata (w_wdata[i]),
            .i_re    (w_re[i]),
            .o_next  (w_next[i]),
            .o_rd    (w_rd[i])
        );
    end

    assign w_rd_or  = w_rd[REG_A] | w_rd[REG_L] | w_rd[REG_Q] | w_rd[REG_Z] | w_rd[REG_G];
    assign bus.RL_n = ~w_rd_or;

    // Flags follow A's next state so they always match the register after the edge.
    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            r_a_ovf <= 1'b0;
            r_a_sgn <= 1'b0;
        end else begin
            r_a_ovf <= w_next[REG_A][S2_BIT] ^ w_next[REG_A][S1_BIT];
            r_a_sgn <= w_next[REG_A][S2_BIT];
        end
    end

    assign bus.A_OVF = r_a_ovf;
    assign bus.A_SGN = r_a_sgn;

    assign w_unused_next = ^{w_next[REG_A], w_next[REG_L], w_next[REG_Q], w_next[REG_Z], w_next[REG_G]};

endmodule
